// File: rtl/strobe_sequencer.sv
// strobe_sequencer
//   Slot timer and strobe generator for the display path. A CNT_WIDTH-bit
//   prescale counter divides the clock into slots of (period+1) cycles. A
//   one-hot channel select rotates across NUM_CH channels, one per slot. A
//   strobe of pulse_len cycles is emitted at the start of every slot. The
//   block runs either continuously or as one sweep with a start/busy/done
//   handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   run        in   level enable; low forces IDLE (abort)
//   one_shot   in   1 = single sweep, 0 = continuous; sampled on entry to RUN
//   start      in   sweep request in one-shot mode
//   period     in   slot length minus 1; sampled at slot boundaries
//   pulse_len  in   strobe high-time in cycles; sampled at slot boundaries
//   ch_sel     out  one-hot active channel, 0 when idle
//   ch_idx     out  binary index of the active channel
//   strobe     out  high for the first pulse_len cycles of each slot
//   slot_tick  out  pulse on the first cycle of each slot
//   busy       out  high while in RUN
//   done       out  one-cycle pulse after a completed one-shot sweep
module strobe_sequencer #(
  parameter int CNT_WIDTH = 23,
  parameter int NUM_CH    = 4,
  parameter int PW_WIDTH  = 5,
  localparam int IDX_W    = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 one_shot,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [PW_WIDTH-1:0]  pulse_len,
  output logic [NUM_CH-1:0]    ch_sel,
  output logic [IDX_W-1:0]     ch_idx,
  output logic                 strobe,
  output logic                 slot_tick,
  output logic                 busy,
  output logic                 done
);

  // Common width for the strobe compare; both operands zero-extended.
  localparam int CMP_W = (CNT_WIDTH > PW_WIDTH) ? CNT_WIDTH : PW_WIDTH;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   per_q, per_d;
  logic [PW_WIDTH-1:0]    len_q, len_d;
  logic                   mode_q, mode_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic [NUM_CH-1:0]      ch_sel_q, ch_sel_d;
  logic [IDX_W-1:0]       ch_idx_q, ch_idx_d;
  logic                   strobe_q, strobe_d;
  logic                   slot_tick_q, slot_tick_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   last_ch;

  assign last_ch = (idx_q == IDX_W'(NUM_CH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    per_d       = per_q;
    len_d       = len_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    ch_sel_d    = '0;
    ch_idx_d    = '0;
    strobe_d    = 1'b0;
    slot_tick_d = 1'b0;
    busy_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // Entry is also legal in a done cycle, giving back-to-back sweeps.
        if (run && (!one_shot || start)) begin
          state_d = RUN;
          per_d   = period;
          len_d   = pulse_len;
          mode_d  = one_shot;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == per_q) begin
          cnt_d = '0;
          if (mode_q && last_ch) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = last_ch ? '0 : idx_q + IDX_W'(1);
            per_d = period;
            len_d = pulse_len;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // line up with the cycle the counter/channel values describe.
    if (state_d == RUN) begin
      ch_sel_d    = NUM_CH'(1) << idx_d;
      ch_idx_d    = idx_d;
      strobe_d    = (CMP_W'(cnt_d) < CMP_W'(len_d));
      slot_tick_d = (cnt_d == '0);
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      per_q       <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      ch_sel_q    <= '0;
      ch_idx_q    <= '0;
      strobe_q    <= 1'b0;
      slot_tick_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      per_q       <= per_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      ch_sel_q    <= ch_sel_d;
      ch_idx_q    <= ch_idx_d;
      strobe_q    <= strobe_d;
      slot_tick_q <= slot_tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ch_sel    = ch_sel_q;
  assign ch_idx    = ch_idx_q;
  assign strobe    = strobe_q;
  assign slot_tick = slot_tick_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_strobe_sequencer.sv
// Bench for strobe_sequencer: two instances (CNT_WIDTH=23 and CNT_WIDTH=4),
// a per-instance reference model feeding expected-output queues on every
// rising edge, compared against the DUT on the falling edge, plus a few
// directed measurements of slot and sweep lengths.
module tb_strobe_sequencer;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        one_shot;
  logic        start;
  logic [22:0] period;
  logic [3:0]  period4;
  logic [4:0]  pulse_len;

  logic [3:0]  ch_sel_a, ch_sel_b;
  logic [1:0]  ch_idx_a, ch_idx_b;
  logic        strobe_a, strobe_b;
  logic        slot_tick_a, slot_tick_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  int n_checks = 0;
  int n_errors = 0;

  strobe_sequencer #(.CNT_WIDTH(23), .NUM_CH(NCH), .PW_WIDTH(5)) u_dut (
    .clk(clk), .reset(reset), .run(run), .one_shot(one_shot), .start(start),
    .period(period), .pulse_len(pulse_len),
    .ch_sel(ch_sel_a), .ch_idx(ch_idx_a), .strobe(strobe_a),
    .slot_tick(slot_tick_a), .busy(busy_a), .done(done_a)
  );

  strobe_sequencer #(.CNT_WIDTH(4), .NUM_CH(NCH), .PW_WIDTH(5)) u_dut4 (
    .clk(clk), .reset(reset), .run(run), .one_shot(one_shot), .start(start),
    .period(period4), .pulse_len(pulse_len),
    .ch_sel(ch_sel_b), .ch_idx(ch_idx_b), .strobe(strobe_b),
    .slot_tick(slot_tick_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] idx;
    logic       stb;
    logic       tick;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int unsigned m_st[2], m_cnt[2], m_idx[2], m_p[2], m_l[2];
  bit          m_os[2];

  function automatic exp_t model_step(input int k, input int unsigned per);
    exp_t e;
    bit   dn;
    dn = 1'b0;
    if (reset) begin
      m_st[k] = 0; m_cnt[k] = 0; m_idx[k] = 0;
    end else if (m_st[k] == 0) begin
      if (run && (!one_shot || start)) begin
        m_st[k] = 1; m_cnt[k] = 0; m_idx[k] = 0;
        m_p[k] = per; m_l[k] = pulse_len; m_os[k] = one_shot;
      end
    end else if (!run) begin
      m_st[k] = 0; m_cnt[k] = 0; m_idx[k] = 0;
    end else if (m_cnt[k] == m_p[k]) begin
      if (m_os[k] && m_idx[k] == NCH - 1) begin
        m_st[k] = 0; m_cnt[k] = 0; m_idx[k] = 0; dn = 1'b1;
      end else begin
        m_cnt[k] = 0;
        m_idx[k] = (m_idx[k] + 1) % NCH;
        m_p[k] = per; m_l[k] = pulse_len;
      end
    end else begin
      m_cnt[k] = m_cnt[k] + 1;
    end
    e = '0;
    if (m_st[k] == 1) begin
      e.sel  = 4'(1 << m_idx[k]);
      e.idx  = 2'(m_idx[k]);
      e.stb  = (m_cnt[k] < m_l[k]);
      e.tick = (m_cnt[k] == 0);
      e.busy = 1'b1;
    end else begin
      e.done = dn;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    sb_a.push_back(model_step(0, 32'(period)));
    sb_b.push_back(model_step(1, 32'(period4)));
  end

  task automatic cmp_out(input string p, input exp_t e, input logic [3:0] sel,
                         input logic [1:0] idx, input logic stb, input logic tck,
                         input logic bsy, input logic dne);
    check({p, "_ch_sel"},    32'(sel), 32'(e.sel));
    check({p, "_ch_idx"},    32'(idx), 32'(e.idx));
    check({p, "_strobe"},    32'(stb), 32'(e.stb));
    check({p, "_slot_tick"}, 32'(tck), 32'(e.tick));
    check({p, "_busy"},      32'(bsy), 32'(e.busy));
    check({p, "_done"},      32'(dne), 32'(e.done));
  endtask

  exp_t ea, eb;
  always @(negedge clk) begin
    if (sb_a.size() == 0) check("sb_a_empty", 0, 1);
    else begin
      ea = sb_a.pop_front();
      cmp_out("a", ea, ch_sel_a, ch_idx_a, strobe_a, slot_tick_a, busy_a, done_a);
    end
    if (sb_b.size() == 0) check("sb_b_empty", 0, 1);
    else begin
      eb = sb_b.pop_front();
      cmp_out("b", eb, ch_sel_b, ch_idx_b, strobe_b, slot_tick_b, busy_b, done_b);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until instance A's model is in RUN at the given channel (-1 = any)
  // and counter value.
  task automatic wait_model(input int idx, input int unsigned cnt, input int maxc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (m_st[0] == 1 && (idx < 0 || m_idx[0] == idx) && m_cnt[0] == cnt) begin
        found = 1'b1;
        break;
      end
      tick_n(1);
    end
    if (!found) check("wait_model_timeout", 0, 1);
  endtask

  // Count falling edges without slot_tick until the next slot_tick.
  task automatic count_until_tick(output int n, input int maxc);
    bit found;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (slot_tick_a) begin
        found = 1'b1;
        break;
      end
      n++;
    end
    if (!found) check("tick_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    int  t;
    bit  found;

    reset = 1'b1; run = 1'b1; one_shot = 1'b0; start = 1'b0;
    period = 23'd3; period4 = 4'hF; pulse_len = 5'd2;

    // Reset held with run=1: outputs stay 0.
    tick_n(3);
    check("rst_ch_sel", 32'(ch_sel_a), 0);
    check("rst_busy",   32'(busy_a),   0);
    reset = 1'b0;

    // Continuous, P=3, L=2: slot 0 on the next edge.
    tick_n(1);
    check("entry_ch_sel", 32'(ch_sel_a),    32'h1);
    check("entry_tick",   32'(slot_tick_a), 1);
    check("entry_strobe", 32'(strobe_a),    1);
    check("entry_busy",   32'(busy_a),      1);
    tick_n(6);
    one_shot = 1'b1;   // ignored while running
    tick_n(4);
    one_shot = 1'b0;
    tick_n(10);

    // Abort at cnt=2 of channel 2, then restart.
    wait_model(2, 2, 20);
    run = 1'b0;
    tick_n(1);
    check("abort_ch_sel", 32'(ch_sel_a), 0);
    check("abort_busy",   32'(busy_a),   0);
    check("abort_done",   32'(done_a),   0);
    tick_n(2);
    run = 1'b1;
    tick_n(1);
    check("restart_ch_sel", 32'(ch_sel_a), 32'h1);
    check("restart_ch_idx", 32'(ch_idx_a), 0);

    // Mid-slot period change 3 -> 5 at cnt=1.
    wait_model(-1, 1, 20);
    period = 23'd5;
    count_until_tick(n, 20);
    check("rem_slot_cycles", n, 3);
    count_until_tick(n, 20);
    check("slot_len_p5", n + 1, 6);

    // L=7 with P=3, then L=0.
    period = 23'd3;
    pulse_len = 5'd7;
    tick_n(14);
    pulse_len = 5'd0;
    tick_n(14);

    // P=0: a new slot every cycle.
    period = 23'd0;
    pulse_len = 5'd1;
    tick_n(8);
    t = 0;
    repeat (8) begin
      @(negedge clk);
      t += int'(slot_tick_a);
    end
    check("p0_ticks", t, 8);

    // One-shot, P=1, L=1.
    tick_n(1);
    run = 1'b0;
    tick_n(2);
    one_shot = 1'b1; period = 23'd1; pulse_len = 5'd1; run = 1'b1;
    tick_n(3);
    check("os_wait_busy", 32'(busy_a), 0);
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy_a) begin
        found = 1'b1;
        break;
      end
      n++;
      if (n == 3) start = 1'b1;   // ignored while busy
      if (n == 4) start = 1'b0;
    end
    if (!found) check("os_busy_timeout", 0, 1);
    check("os_busy_cycles", n, 8);
    check("os_done_pulse",  32'(done_a), 1);
    @(negedge clk);
    check("os_done_cleared", 32'(done_a), 0);
    check("os_idle_busy",    32'(busy_a), 0);

    // Let the short-counter instance finish its 64-cycle sweep.
    tick_n(70);

    // Back-to-back: new start accepted in the done cycle.
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("b2b_done_timeout", 0, 1);
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    check("b2b_busy",   32'(busy_a),   1);
    check("b2b_done",   32'(done_a),   0);
    check("b2b_ch_sel", 32'(ch_sel_a), 32'h1);
    tick_n(80);

    run = 1'b0;
    tick_n(3);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
